// File: rtl/div_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential restoring divider.
package div_pkg;

    // Operand/result width and iteration count (one quotient bit per cycle).
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned ITERATIONS = WIDTH;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    // FSM encoding.
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_FIX  = 2'd2;

    // Most negative value; its magnitude wraps to itself when negated.
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit and trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_q_bit_c
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so a WIDTH+1-bit
    // difference is wide enough for its MSB to act as the borrow/sign.
    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_dvs};

    // Keep the difference when non-negative, otherwise restore the shifted value.
    assign o_q_bit_c = ~w_diff[WIDTH];
    assign o_rem_c   = o_q_bit_c ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Sequential 16-bit signed/unsigned restoring divider with start/busy/done handshake.
module div
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    // State and datapath registers.
    logic [ST_W-1:0]  r_state;
    logic             r_signed;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_ovf_pend;
    logic [WIDTH-1:0] r_dvd;     // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0] r_dvs;     // divisor magnitude
    logic [WIDTH-1:0] r_rem;     // partial remainder
    logic [CNT_W-1:0] r_cnt;

    // Registered outputs.
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;
    logic             r_ovf;

    // Next-state values.
    logic [ST_W-1:0]  w_state;
    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_ovf_pend;
    logic [WIDTH-1:0] w_dvd;
    logic [WIDTH-1:0] w_dvs;
    logic [WIDTH-1:0] w_rem;
    logic [CNT_W-1:0] w_cnt;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_remo;
    logic             w_dbz;
    logic             w_ovf;

    // Step datapath outputs.
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

    // Single restoring iteration on the current partial remainder.
    div_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_dvs     (r_dvs),
        .o_rem_c   (w_step_rem),
        .o_q_bit_c (w_step_q)
    );

    // Next-state and output logic: accept, iterate, then sign-fix and publish.
    always_comb begin
        w_state    = r_state;
        w_signed   = r_signed;
        w_neg_a    = r_neg_a;
        w_neg_b    = r_neg_b;
        w_ovf_pend = r_ovf_pend;
        w_dvd      = r_dvd;
        w_dvs      = r_dvs;
        w_rem      = r_rem;
        w_cnt      = r_cnt;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_quot     = r_quot;
        w_remo     = r_remo;
        w_dbz      = r_dbz;
        w_ovf      = r_ovf;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_dbz = 1'b0;
                    w_ovf = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor completes immediately without iterating.
                        w_quot = '1;
                        w_remo = dividend;
                        w_dbz  = 1'b1;
                        w_done = 1'b1;
                    end else begin
                        w_state    = ST_RUN;
                        w_busy     = 1'b1;
                        w_signed   = signed_op;
                        w_neg_a    = signed_op & dividend[WIDTH-1];
                        w_neg_b    = signed_op & divisor[WIDTH-1];
                        w_dvd      = cond_neg(dividend, signed_op & dividend[WIDTH-1]);
                        w_dvs      = cond_neg(divisor, signed_op & divisor[WIDTH-1]);
                        w_rem      = '0;
                        w_cnt      = '0;
                        w_ovf_pend = signed_op & (dividend == MIN_NEG) & (divisor == '1);
                    end
                end
            end

            ST_RUN: begin
                w_dvd = {r_dvd[WIDTH-2:0], w_step_q};
                w_rem = w_step_rem;
                w_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
                    w_state = ST_FIX;
                end
            end

            ST_FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                w_quot  = cond_neg(r_dvd, r_signed & (r_neg_a ^ r_neg_b));
                w_remo  = cond_neg(r_rem, r_signed & r_neg_a);
                w_ovf   = r_ovf_pend;
                w_dbz   = 1'b0;
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous clear of every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_signed   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_remo     <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_signed   <= w_signed;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_ovf_pend <= w_ovf_pend;
            r_dvd      <= w_dvd;
            r_dvs      <= w_dvs;
            r_rem      <= w_rem;
            r_cnt      <= w_cnt;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_quot     <= w_quot;
            r_remo     <= w_remo;
            r_dbz      <= w_dbz;
            r_ovf      <= w_ovf;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
